// File: rtl/mem_access_unit_pkg.sv
// Shared types and lane helpers for the load/store memory responder.
package mem_access_unit_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_WAIT  = 3'd1,
        ST_MERGE_WR = 3'd2,
        ST_WR       = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    function automatic logic is_misaligned(
        input logic [1:0] addr_lo,
        input logic [1:0] size
    );
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = |addr_lo;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] lane_extract(
        input logic [31:0] word,
        input logic [1:0]  addr_lo,
        input logic [1:0]  size,
        input logic        sign
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (addr_lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: r = {{24{sign & b[7]}}, b};
            SIZE_HALF: r = {{16{sign & h[15]}}, h};
            default:   r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_merge(
        input logic [31:0] word,
        input logic [31:0] wdata,
        input logic [1:0]  addr_lo,
        input logic [1:0]  size
    );
        logic [31:0] r;
        r = word;
        case (size)
            SIZE_BYTE: begin
                case (addr_lo)
                    2'd0:    r[7:0]   = wdata[7:0];
                    2'd1:    r[15:8]  = wdata[7:0];
                    2'd2:    r[23:16] = wdata[7:0];
                    default: r[31:24] = wdata[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (addr_lo[1]) r[31:16] = wdata[15:0];
                else            r[15:0]  = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane extract (loads) and lane merge (sub-word stores).
module mem_lane_align (
    input  logic [31:0] rd_word,
    input  logic [31:0] wr_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] ext,
    output logic [31:0] merged
);
    import mem_access_unit_pkg::*;

    assign ext    = lane_extract(rd_word, addr_lo, size, sign);
    assign merged = lane_merge(wr_word, wdata, addr_lo, size);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store responder: ready/valid request in, fixed-latency word RAM out.
module mem_access_unit #(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic [ADDR_W-3:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    import mem_access_unit_pkg::*;

    localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

    state_t            state;
    state_t            state_nx;
    logic              run_q;
    logic [2:0]        cnt_q;
    logic              we_q;
    logic              sign_q;
    logic              err_q;
    logic [1:0]        size_q;
    logic [1:0]        lo_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word_q;
    logic [31:0]       rdata_q;
    logic [ADDR_W-3:0] addr_q;
    logic              accept;
    logic              bad;
    logic              rd_done;
    logic [31:0]       ext_word;
    logic [31:0]       merged;

    assign accept  = req_valid && req_ready;
    assign bad     = is_misaligned(req_addr[1:0], req_size);
    assign rd_done = (state == ST_RD_WAIT) && (cnt_q == 3'd0);

    mem_lane_align u_align (
        .rd_word (ram_rdata),
        .wr_word (word_q),
        .wdata   (wdata_q),
        .addr_lo (lo_q),
        .size    (size_q),
        .sign    (sign_q),
        .ext     (ext_word),
        .merged  (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (bad)
                        state_nx = ST_RESP;
                    else if (req_we && req_size == SIZE_WORD)
                        state_nx = ST_WR;
                    else
                        state_nx = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == 3'd0)
                    state_nx = we_q ? ST_MERGE_WR : ST_RESP;
            end
            ST_MERGE_WR: state_nx = ST_RESP;
            ST_WR:       state_nx = ST_RESP;
            ST_RESP:     state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            cnt_q   <= 3'd0;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            lo_q    <= 2'b00;
            wdata_q <= 32'd0;
            word_q  <= 32'd0;
            rdata_q <= 32'd0;
            addr_q  <= '0;
        end else begin
            run_q <= 1'b1;
            if (accept) begin
                cnt_q   <= CNT_INIT;
                we_q    <= req_we;
                sign_q  <= req_signed;
                err_q   <= bad;
                size_q  <= req_size;
                lo_q    <= req_addr[1:0];
                wdata_q <= req_wdata;
                addr_q  <= req_addr[ADDR_W-1:2];
            end else if (state == ST_RD_WAIT && cnt_q != 3'd0) begin
                cnt_q <= cnt_q - 3'd1;
            end
            // Stores keep the raw word for merging; loads update the result.
            if (rd_done) begin
                if (we_q) word_q  <= ram_rdata;
                else      rdata_q <= ext_word;
            end
        end
    end

    always_comb begin
        req_ready = (state == ST_IDLE) && run_q;
        rsp_valid = (state == ST_RESP);
        rsp_err   = (state == ST_RESP) && err_q;
        rsp_rdata = rsp_err ? 32'd0 : rdata_q;
        ram_addr  = addr_q;
        ram_we    = (state == ST_MERGE_WR) || (state == ST_WR);
        ram_wdata = 32'd0;
        if (state == ST_MERGE_WR) ram_wdata = merged;
        if (state == ST_WR)       ram_wdata = wdata_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed vectors plus reset and back-to-back sequences for mem_access_unit.
module tb_mem_access_unit;

    localparam int RD_LAT = 2;
    localparam int LD     = RD_LAT + 1;
    localparam int SSW    = RD_LAT + 1;
    localparam int SSR    = RD_LAT + 2;
    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b10;
    localparam logic [1:0] SX = 2'b11;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          rsp_cyc;
        int          we_cyc;
        logic [31:0] ram_wd;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [29:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] mem [16];
    logic [31:0] rd_q;
    int          n_pass;
    int          n_tot;
    vec_t        vecs [23];

    mem_access_unit #(.RD_LAT(RD_LAT), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One register stage: data for ram_addr is ready RD_LAT=2 edges after accept.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
            mem[4] <= 32'h8899AABB;
            mem[5] <= 32'h11223344;
        end else if (ram_we) begin
            mem[ram_addr[3:0]] <= ram_wdata;
        end
        rd_q <= mem[ram_addr[3:0]];
    end
    assign ram_rdata = rd_q;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size,
                                input logic sign, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic err,
                                input logic [31:0] rdata, input int rsp_cyc,
                                input int we_cyc, input logic [31:0] ram_wd);
        vec_t v;
        v.we = we; v.size = size; v.sign = sign; v.addr = addr;
        v.wdata = wdata; v.err = err; v.rdata = rdata;
        v.rsp_cyc = rsp_cyc; v.we_cyc = we_cyc; v.ram_wd = ram_wd;
        return v;
    endfunction

    task automatic drive(input logic we, input logic [1:0] size,
                         input logic sign, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req_valid = 1'b1; req_we = we; req_size = size;
        req_signed = sign; req_addr = addr; req_wdata = wdata;
    endtask

    task automatic run_vec(input int idx);
        vec_t        v;
        int          rsp_cyc, we_cnt, we_cyc;
        logic        got, err, rdy_bad, rdy_after;
        logic [31:0] rd, wd;
        logic [29:0] ra;
        string       t;
        v = vecs[idx];
        t = $sformatf("vec%0d", idx);
        @(negedge clk);
        chk({t, " ready_idle"}, {31'd0, req_ready}, 32'd1);
        drive(v.we, v.size, v.sign, v.addr, v.wdata);
        @(negedge clk);
        req_valid = 1'b0;
        got = 0; err = 0; rdy_bad = 0; rdy_after = 0;
        rsp_cyc = 0; we_cnt = 0; we_cyc = 0; rd = 0; wd = 0; ra = 0;
        for (int c = 1; c <= 14; c++) begin
            if (ram_we) begin we_cnt++; we_cyc = c; wd = ram_wdata; end
            if (got && c == rsp_cyc + 1) begin
                rdy_after = req_ready;
                break;
            end
            if (req_ready) rdy_bad = 1;
            if (rsp_valid && !got) begin
                got = 1; rsp_cyc = c; err = rsp_err;
                rd = rsp_rdata; ra = ram_addr;
            end
            @(negedge clk);
        end
        chk({t, " rsp_seen"}, {31'd0, got}, 32'd1);
        chk({t, " rsp_cycle"}, rsp_cyc, v.rsp_cyc);
        chk({t, " rsp_err"}, {31'd0, err}, {31'd0, v.err});
        chk({t, " rsp_rdata"}, rd, v.rdata);
        chk({t, " ram_addr"}, {2'b00, ra}, v.addr >> 2);
        chk({t, " ram_we_count"}, we_cnt, (v.we_cyc != 0) ? 1 : 0);
        if (v.we_cyc != 0) begin
            chk({t, " ram_we_cycle"}, we_cyc, v.we_cyc);
            chk({t, " ram_wdata"}, wd, v.ram_wd);
        end
        chk({t, " ready_low_busy"}, {31'd0, rdy_bad}, 32'd0);
        chk({t, " ready_after"}, {31'd0, rdy_after}, 32'd1);
    endtask

    initial begin
        logic found;
        int   rc;
        n_pass = 0; n_tot = 0;
        rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SB;
        req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;

        vecs[0]  = mk(0, SW, 0, 32'h10, 0, 0, 32'h8899AABB, LD, 0, 0);
        vecs[1]  = mk(0, SB, 1, 32'h13, 0, 0, 32'hFFFFFF88, LD, 0, 0);
        vecs[2]  = mk(0, SB, 0, 32'h13, 0, 0, 32'h00000088, LD, 0, 0);
        vecs[3]  = mk(0, SH, 1, 32'h12, 0, 0, 32'hFFFF8899, LD, 0, 0);
        vecs[4]  = mk(0, SH, 0, 32'h10, 0, 0, 32'h0000AABB, LD, 0, 0);
        vecs[5]  = mk(0, SB, 1, 32'h11, 0, 0, 32'hFFFFFFAA, LD, 0, 0);
        vecs[6]  = mk(0, SW, 1, 32'h10, 0, 0, 32'h8899AABB, LD, 0, 0);
        vecs[7]  = mk(1, SB, 0, 32'h11, 32'h5A, 0, 32'h8899AABB,
                      SSR, SSW, 32'h88995ABB);
        vecs[8]  = mk(0, SW, 0, 32'h10, 0, 0, 32'h88995ABB, LD, 0, 0);
        vecs[9]  = mk(1, SH, 0, 32'h12, 32'hFFFF1234, 0, 32'h88995ABB,
                      SSR, SSW, 32'h12345ABB);
        vecs[10] = mk(0, SB, 1, 32'h12, 0, 0, 32'h00000034, LD, 0, 0);
        vecs[11] = mk(0, SH, 1, 32'h12, 0, 0, 32'h00001234, LD, 0, 0);
        vecs[12] = mk(1, SB, 0, 32'h10, 32'hC3, 0, 32'h00001234,
                      SSR, SSW, 32'h12345AC3);
        vecs[13] = mk(0, SB, 1, 32'h10, 0, 0, 32'hFFFFFFC3, LD, 0, 0);
        vecs[14] = mk(1, SW, 0, 32'h14, 32'hCAFEF00D, 0, 32'hFFFFFFC3,
                      2, 1, 32'hCAFEF00D);
        vecs[15] = mk(0, SW, 0, 32'h14, 0, 0, 32'hCAFEF00D, LD, 0, 0);
        vecs[16] = mk(0, SW, 0, 32'h22, 0, 1, 32'h0, 1, 0, 0);
        vecs[17] = mk(0, SX, 0, 32'h20, 0, 1, 32'h0, 1, 0, 0);
        vecs[18] = mk(1, SH, 0, 32'h11, 32'hFFFF, 1, 32'h0, 1, 0, 0);
        vecs[19] = mk(1, SW, 0, 32'h16, 32'h1, 1, 32'h0, 1, 0, 0);
        vecs[20] = mk(0, SB, 0, 32'h17, 0, 0, 32'h000000CA, LD, 0, 0);
        vecs[21] = mk(1, SB, 0, 32'h15, 32'h11, 0, 32'h000000CA,
                      SSR, SSW, 32'hCAFE110D);
        vecs[22] = mk(0, SW, 0, 32'h14, 0, 0, 32'hCAFE110D, LD, 0, 0);

        #1 rst_n = 1'b0;
        #2;
        chk("rst req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'd0);
        chk("rst ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst ram_addr", {2'b00, ram_addr}, 32'd0);
        chk("rst ram_wdata", ram_wdata, 32'd0);
        repeat (2) @(negedge clk);
        chk("rst ready_held", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 23; i++) run_vec(i);

        // Word store followed by a load held on req_valid while busy.
        @(negedge clk);
        drive(1, SW, 0, 32'h20, 32'hDEADBEEF);
        @(negedge clk);
        chk("b2b c1 ready", {31'd0, req_ready}, 32'd0);
        chk("b2b c1 ram_we", {31'd0, ram_we}, 32'd1);
        chk("b2b c1 ram_wdata", ram_wdata, 32'hDEADBEEF);
        chk("b2b c1 ram_addr", {2'b00, ram_addr}, 32'h8);
        drive(0, SW, 0, 32'h20, 32'h0);
        @(negedge clk);
        chk("b2b c2 rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("b2b c2 ram_we", {31'd0, ram_we}, 32'd0);
        chk("b2b c2 ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("b2b c3 ready", {31'd0, req_ready}, 32'd1);
        chk("b2b c3 rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("b2b c4 ready", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0;
        found = 0; rc = 0;
        for (int c = 4; c <= 14; c++) begin
            if (rsp_valid && !found) begin
                found = 1; rc = c;
                chk("b2b load rdata", rsp_rdata, 32'hDEADBEEF);
            end
            if (!found) @(negedge clk);
        end
        chk("b2b load rsp_cycle", rc, 3 + RD_LAT + 1);

        // Reset while the merge write is on the RAM port.
        @(negedge clk);
        @(negedge clk);
        drive(1, SB, 0, 32'h14, 32'h77);
        @(negedge clk);
        req_valid = 1'b0;
        found = 0;
        for (int c = 1; c <= 10; c++) begin
            if (ram_we && !found) found = 1;
            if (!found) @(negedge clk);
        end
        chk("abort merge_wr seen", {31'd0, found}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort ram_we", {31'd0, ram_we}, 32'd0);
        chk("abort ram_wdata", ram_wdata, 32'd0);
        chk("abort rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort req_ready", {31'd0, req_ready}, 32'd0);
        chk("abort ram_addr", {2'b00, ram_addr}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort ready_after", {31'd0, req_ready}, 32'd1);
        found = 0;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid) found = 1;
            @(negedge clk);
        end
        chk("abort no_rsp", {31'd0, found}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
